// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter SDRAM port and its round-robin arbiter.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_CMD
    } blit_port_state_t;

    localparam int BLIT_WORD_BYTES = 4;

endpackage

// File: rtl/blit_rr_arb.sv
// Two-requester round-robin arbiter: when both requests are pending, the side
// not granted last wins. After reset, requester A (the read port) is favoured.
module blit_rr_arb (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic prefer_a_q;
    logic prefer_a_d;

    always_comb begin
        grant_a    = enable && req_a && (!req_b || prefer_a_q);
        grant_b    = enable && req_b && (!req_a || !prefer_a_q);
        prefer_a_d = prefer_a_q;
        // Every grant hands priority to the other side, even an uncontested one.
        if (grant_a) begin
            prefer_a_d = 1'b0;
        end else if (grant_b) begin
            prefer_a_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_a_q <= 1'b1;
        end else begin
            prefer_a_q <= prefer_a_d;
        end
    end

endmodule

// File: rtl/blit_sdram_port.sv
// Blitter SDRAM port: arbitrates the burst-read and single-write ports onto one controller
// command port. Define BLIT_SDRAM_PORT_STATS_EN to add read-burst and write counters.
module blit_sdram_port
    import blit_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blitr_sdram_request,
    input  logic [ADDR_W-1:0] blitr_sdram_address,
    output logic              blitr_sdram_ready,
    output logic              blitr_sdram_rvalid,
    output logic [31:0]       blitr_sdram_rdata,
    output logic [ADDR_W-1:0] blitr_sdram_raddress,
    output logic              blitr_sdram_complete,
    input  logic              blitw_sdram_request,
    output logic              blitw_sdram_ready,
    input  logic [ADDR_W-1:0] blitw_sdram_address,
    input  logic [3:0]        blitw_sdram_wstrb,
    input  logic [31:0]       blitw_sdram_wdata,
    output logic              mem_request,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef BLIT_SDRAM_PORT_STATS_EN
    ,
    output logic [31:0]       stat_read_bursts,
    output logic [31:0]       stat_writes
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BURST_MASK = ADDR_W'(BURST_LEN * BLIT_WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ADDR_W'(BLIT_WORD_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    blit_port_state_t  state_q, state_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] raddress_q, raddress_d;
    logic              complete_q, complete_d;
    logic              grant_r;
    logic              grant_w;

    blit_rr_arb u_arb (
        .clock   (clock),
        .reset   (reset),
        .enable  (state_q == IDLE),
        .req_a   (blitr_sdram_request),
        .req_b   (blitw_sdram_request),
        .grant_a (grant_r),
        .grant_b (grant_w)
    );

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        beat_d     = beat_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        raddress_d = raddress_q;
        complete_d = 1'b0;
        case (state_q)
            IDLE: begin
                // cmd_addr holds the burst-aligned base for reads, so beat addresses derive from it.
                if (grant_r) begin
                    state_d    = RD_CMD;
                    cmd_addr_d = blitr_sdram_address & ~BURST_MASK;
                end else if (grant_w) begin
                    state_d    = WR_CMD;
                    cmd_addr_d = blitw_sdram_address & ~WORD_MASK;
                    wstrb_d    = blitw_sdram_wstrb;
                    wdata_d    = blitw_sdram_wdata;
                end
            end
            RD_CMD: begin
                if (mem_ready) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = mem_rdata;
                    raddress_d = cmd_addr_q + ADDR_W'(beat_q) * ADDR_W'(BLIT_WORD_BYTES);
                    beat_d     = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        complete_d = 1'b1;
                        beat_d     = '0;
                        state_d    = IDLE;
                    end
                end
            end
            WR_CMD: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_addr_q <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            beat_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            raddress_q <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            beat_q     <= beat_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            raddress_q <= raddress_d;
            complete_q <= complete_d;
        end
    end

    // Ready is combinational so an initiator can drop its request in the accepting cycle.
    assign blitr_sdram_ready    = (state_q == RD_CMD) && mem_ready;
    assign blitw_sdram_ready    = (state_q == WR_CMD) && mem_ready;
    assign blitr_sdram_rvalid   = rvalid_q;
    assign blitr_sdram_rdata    = rdata_q;
    assign blitr_sdram_raddress = raddress_q;
    assign blitr_sdram_complete = complete_q;
    assign mem_request          = (state_q == RD_CMD) || (state_q == WR_CMD);
    assign mem_write            = (state_q == WR_CMD);
    assign mem_address          = cmd_addr_q;
    assign mem_wstrb            = wstrb_q;
    assign mem_wdata            = wdata_q;

`ifdef BLIT_SDRAM_PORT_STATS_EN
    logic [31:0] stat_read_bursts_q, stat_read_bursts_d;
    logic [31:0] stat_writes_q, stat_writes_d;

    always_comb begin
        stat_read_bursts_d = stat_read_bursts_q + {31'd0, complete_q};
        stat_writes_d      = stat_writes_q + {31'd0, blitw_sdram_ready};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_read_bursts_q <= '0;
            stat_writes_q      <= '0;
        end else begin
            stat_read_bursts_q <= stat_read_bursts_d;
            stat_writes_q      <= stat_writes_d;
        end
    end

    assign stat_read_bursts = stat_read_bursts_q;
    assign stat_writes      = stat_writes_q;
`endif

endmodule

// File: tb/tb_blit_sdram_port.sv
// Self-checking bench for blit_sdram_port: table of read/write transactions plus
// hand-written arbitration, gap, throughput and reset-mid-burst sequences.
module tb_blit_sdram_port;

   localparam int BL = 8;
   localparam int AW = 26;

   typedef struct {
      bit          isWrite;
      logic [25:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [25:0] expAddr;
      bit          gaps;
   } vec_t;

   typedef struct {
      logic [25:0] addr;
      logic [31:0] data;
      bit          last;
   } beat_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          blitr_sdram_request = 1'b0;
   logic [AW-1:0] blitr_sdram_address = '0;
   logic          blitr_sdram_ready;
   logic          blitr_sdram_rvalid;
   logic [31:0]   blitr_sdram_rdata;
   logic [AW-1:0] blitr_sdram_raddress;
   logic          blitr_sdram_complete;
   logic          blitw_sdram_request = 1'b0;
   logic          blitw_sdram_ready;
   logic [AW-1:0] blitw_sdram_address = '0;
   logic [3:0]    blitw_sdram_wstrb = '0;
   logic [31:0]   blitw_sdram_wdata = '0;
   logic          mem_request;
   logic          mem_ready = 1'b0;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_wstrb;
   logic [31:0]   mem_wdata;
   logic          mem_rvalid = 1'b0;
   logic [31:0]   mem_rdata = '0;
`ifdef BLIT_SDRAM_PORT_STATS_EN
   logic [31:0]   stat_read_bursts;
   logic [31:0]   stat_writes;
`endif

   int    nCompared = 0;
   int    nMismatched = 0;
   int    rdReadyCnt = 0;
   int    wrReadyCnt = 0;
   beat_t sb[$];
   beat_t monExp;
   vec_t  vecs[$];

   blit_sdram_port #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
      .clock                (clock),
      .reset                (reset),
      .blitr_sdram_request  (blitr_sdram_request),
      .blitr_sdram_address  (blitr_sdram_address),
      .blitr_sdram_ready    (blitr_sdram_ready),
      .blitr_sdram_rvalid   (blitr_sdram_rvalid),
      .blitr_sdram_rdata    (blitr_sdram_rdata),
      .blitr_sdram_raddress (blitr_sdram_raddress),
      .blitr_sdram_complete (blitr_sdram_complete),
      .blitw_sdram_request  (blitw_sdram_request),
      .blitw_sdram_ready    (blitw_sdram_ready),
      .blitw_sdram_address  (blitw_sdram_address),
      .blitw_sdram_wstrb    (blitw_sdram_wstrb),
      .blitw_sdram_wdata    (blitw_sdram_wdata),
      .mem_request          (mem_request),
      .mem_ready            (mem_ready),
      .mem_write            (mem_write),
      .mem_address          (mem_address),
      .mem_wstrb            (mem_wstrb),
      .mem_wdata            (mem_wdata),
      .mem_rvalid           (mem_rvalid),
      .mem_rdata            (mem_rdata)
`ifdef BLIT_SDRAM_PORT_STATS_EN
      ,
      .stat_read_bursts     (stat_read_bursts),
      .stat_writes          (stat_writes)
`endif
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Counts ready pulses and pops the scoreboard whenever the port emits a read beat.
   always @(negedge clock) begin
      if (blitr_sdram_ready) rdReadyCnt++;
      if (blitw_sdram_ready) wrReadyCnt++;
      if (blitr_sdram_rvalid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
         end else begin
            monExp = sb.pop_front();
            checkOutput("beat_raddress", 32'(blitr_sdram_raddress), 32'(monExp.addr));
            checkOutput("beat_rdata", blitr_sdram_rdata, monExp.data);
            checkOutput("beat_complete", 32'(blitr_sdram_complete), 32'(monExp.last));
         end
      end else if (blitr_sdram_complete) begin
         checkOutput("complete_without_beat", 32'd1, 32'd0);
      end
   end

   // Hard stop in case some wait escapes its bound.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitMemRequest(output int cyc);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!mem_request && cyc < 50);
      if (!mem_request) checkOutput("mem_request_timeout", 32'd0, 32'd1);
   endtask

   task automatic deliverBeats(input logic [25:0] base, input bit gaps);
      int gapTab[8] = '{0, 2, 0, 4, 1, 0, 3, 0};
      for (int i = 0; i < BL; i++) begin
         if (gaps) begin
            for (int g = 0; g < gapTab[i % 8]; g++) begin
               @(posedge clock); #1;
               mem_rvalid = 1'b0;
            end
         end
         @(posedge clock); #1;
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         sb.push_back(beat_t'{base + 26'(4 * i), mem_rdata, (i == BL - 1)});
      end
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("burst_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic doRead(input logic [25:0] addr, input logic [25:0] expBase, input bit gaps);
      int cyc;
      int rd0;
      @(posedge clock); #1;
      blitr_sdram_request = 1'b1;
      blitr_sdram_address = addr;
      rd0 = rdReadyCnt;
      waitMemRequest(cyc);
      checkOutput("rd_cmd_latency", 32'(cyc), 32'd2);
      checkOutput("rd_mem_write", 32'(mem_write), 32'd0);
      checkOutput("rd_mem_address", 32'(mem_address), 32'(expBase));
      checkOutput("rd_ready_before_accept", 32'(blitr_sdram_ready), 32'd0);
      @(posedge clock); #1;
      mem_ready = 1'b1;
      @(negedge clock);
      checkOutput("rd_ready_pulse", 32'(blitr_sdram_ready), 32'd1);
      checkOutput("rd_no_w_ready", 32'(blitw_sdram_ready), 32'd0);
      @(posedge clock); #1;
      mem_ready = 1'b0;
      blitr_sdram_request = 1'b0;
      @(negedge clock);
      checkOutput("rd_cmd_dropped", 32'(mem_request), 32'd0);
      checkOutput("rd_ready_count", 32'(rdReadyCnt - rd0), 32'd1);
      deliverBeats(expBase, gaps);
   endtask

   task automatic doWrite(input logic [25:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input logic [25:0] expAddr);
      int cyc;
      int wr0;
      @(posedge clock); #1;
      blitw_sdram_request = 1'b1;
      blitw_sdram_address = addr;
      blitw_sdram_wstrb   = wstrb;
      blitw_sdram_wdata   = wdata;
      wr0 = wrReadyCnt;
      waitMemRequest(cyc);
      checkOutput("wr_cmd_latency", 32'(cyc), 32'd2);
      checkOutput("wr_mem_write", 32'(mem_write), 32'd1);
      checkOutput("wr_mem_address", 32'(mem_address), 32'(expAddr));
      checkOutput("wr_mem_wstrb", 32'(mem_wstrb), 32'(wstrb));
      checkOutput("wr_mem_wdata", mem_wdata, wdata);
      @(posedge clock); #1;
      mem_ready = 1'b1;
      @(negedge clock);
      checkOutput("wr_ready_pulse", 32'(blitw_sdram_ready), 32'd1);
      checkOutput("wr_no_r_ready", 32'(blitr_sdram_ready), 32'd0);
      @(posedge clock); #1;
      mem_ready = 1'b0;
      blitw_sdram_request = 1'b0;
      @(negedge clock);
      checkOutput("wr_cmd_dropped", 32'(mem_request), 32'd0);
      checkOutput("wr_ready_count", 32'(wrReadyCnt - wr0), 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.isWrite) doWrite(v.addr, v.wstrb, v.wdata, v.expAddr);
      else           doRead(v.addr, v.expAddr, v.gaps);
   endtask

   initial begin
      int cyc;
      int pulses;
      int backToBack;
      bit prev;

      vecs.push_back(vec_t'{1'b0, 26'h0001234, 4'h0, 32'h0,         26'h0001220, 1'b0});
      vecs.push_back(vec_t'{1'b1, 26'h0000103, 4'b0010, 32'hDEADBEEF, 26'h0000100, 1'b0});
      vecs.push_back(vec_t'{1'b0, 26'h3FFFFFF, 4'h0, 32'h0,         26'h3FFFFE0, 1'b0});
      vecs.push_back(vec_t'{1'b1, 26'h3FFFFFE, 4'b1111, 32'hA5A5F00D, 26'h3FFFFFC, 1'b0});
      vecs.push_back(vec_t'{1'b0, 26'h0000020, 4'h0, 32'h0,         26'h0000020, 1'b1});
      vecs.push_back(vec_t'{1'b1, 26'h0000001, 4'b1000, 32'h0BADCAFE, 26'h0000000, 1'b0});

      // Reset values.
      #12;
      checkOutput("rst_mem_request", 32'(mem_request), 32'd0);
      checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
      checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
      checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("rst_r_ready", 32'(blitr_sdram_ready), 32'd0);
      checkOutput("rst_w_ready", 32'(blitw_sdram_ready), 32'd0);
      checkOutput("rst_rvalid", 32'(blitr_sdram_rvalid), 32'd0);
      checkOutput("rst_rdata", blitr_sdram_rdata, 32'd0);
      checkOutput("rst_raddress", 32'(blitr_sdram_raddress), 32'd0);
      checkOutput("rst_complete", 32'(blitr_sdram_complete), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Both ports requesting from reset: read, write, read, write.
      $display("[TB] arbitration sequence");
      @(posedge clock); #1;
      blitr_sdram_request = 1'b1;
      blitr_sdram_address = 26'h0000088;
      blitw_sdram_request = 1'b1;
      blitw_sdram_address = 26'h0000206;
      blitw_sdram_wstrb   = 4'b1100;
      blitw_sdram_wdata   = 32'h12345678;
      for (int k = 0; k < 4; k++) begin
         waitMemRequest(cyc);
         checkOutput($sformatf("arb_grant_%0d", k), 32'(mem_write), 32'(k % 2));
         checkOutput($sformatf("arb_addr_%0d", k), 32'(mem_address),
                     (k % 2 == 1) ? 32'h0000204 : 32'h0000080);
         @(posedge clock); #1;
         mem_ready = 1'b1;
         @(negedge clock);
         checkOutput($sformatf("arb_ready_%0d", k),
                     32'((k % 2 == 1) ? blitw_sdram_ready : blitr_sdram_ready), 32'd1);
         @(posedge clock); #1;
         mem_ready = 1'b0;
         if (k == 3) begin
            blitr_sdram_request = 1'b0;
            blitw_sdram_request = 1'b0;
         end
         if (k % 2 == 0) deliverBeats(26'h0000080, 1'b0);
      end
      repeat (3) @(negedge clock);
      checkOutput("arb_idle_after", 32'(mem_request), 32'd0);

      // Table of single-port transactions.
      $display("[TB] table vectors");
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Burst with gaps between beats (beats at cycles 0,3,4,9,...).
      $display("[TB] gapped burst");
      doRead(26'h00007F0, 26'h00007E0, 1'b1);

      // Stray rvalid while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(negedge clock);
         checkOutput("stray_idle_rvalid", 32'(blitr_sdram_rvalid), 32'd0);
      end
      @(posedge clock); #1;
      mem_rvalid = 1'b0;

      // Write throughput with request and mem_ready held high.
      $display("[TB] write throughput");
      @(posedge clock); #1;
      blitw_sdram_request = 1'b1;
      blitw_sdram_address = 26'h0000010;
      blitw_sdram_wstrb   = 4'b1111;
      blitw_sdram_wdata   = 32'hCAFEF00D;
      mem_ready = 1'b1;
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!blitw_sdram_ready && cyc < 20);
      checkOutput("wr_first_accept", 32'(blitw_sdram_ready), 32'd1);
      pulses = 0;
      backToBack = 0;
      prev = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (blitw_sdram_ready) begin
            pulses++;
            if (prev) backToBack++;
         end
         prev = blitw_sdram_ready;
      end
      checkOutput("wr_pulses_in_10", 32'(pulses), 32'd5);
      checkOutput("wr_back_to_back", 32'(backToBack), 32'd0);
      @(posedge clock); #1;
      blitw_sdram_request = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clock);

      // Reset after three beats while the controller keeps streaming.
      $display("[TB] reset mid-burst");
      @(posedge clock); #1;
      blitr_sdram_request = 1'b1;
      blitr_sdram_address = 26'h0000404;
      waitMemRequest(cyc);
      checkOutput("rst_burst_addr", 32'(mem_address), 32'h0000400);
      @(posedge clock); #1;
      mem_ready = 1'b1;
      @(posedge clock); #1;
      mem_ready = 1'b0;
      blitr_sdram_request = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         sb.push_back(beat_t'{26'h0000400 + 26'(4 * i), mem_rdata, 1'b0});
      end
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      checkOutput("midrst_rvalid", 32'(blitr_sdram_rvalid), 32'd0);
      checkOutput("midrst_complete", 32'(blitr_sdram_complete), 32'd0);
      checkOutput("midrst_mem_request", 32'(mem_request), 32'd0);
      checkOutput("midrst_raddress", 32'(blitr_sdram_raddress), 32'd0);
      sb.delete();
      repeat (3) begin
         @(posedge clock); #1;
         mem_rdata = $urandom;
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("stray_after_reset_rvalid", 32'(blitr_sdram_rvalid), 32'd0);
         checkOutput("stray_after_reset_complete", 32'(blitr_sdram_complete), 32'd0);
      end
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      doRead(26'h0000404, 26'h0000400, 1'b0);

`ifdef BLIT_SDRAM_PORT_STATS_EN
      $display("[TB] statistics counters");
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkOutput("stat_reads_reset", stat_read_bursts, 32'd0);
      checkOutput("stat_writes_reset", stat_writes, 32'd0);
      for (int i = 0; i < 3; i++) doRead(26'h0001000 + 26'(64 * i), 26'h0001000 + 26'(64 * i), 1'b0);
      for (int i = 0; i < 5; i++) doWrite(26'h0002000 + 26'(4 * i), 4'b0101, 32'(i), 26'h0002000 + 26'(4 * i));
      repeat (2) @(negedge clock);
      checkOutput("stat_read_bursts", stat_read_bursts, 32'd3);
      checkOutput("stat_writes", stat_writes, 32'd5);
`endif

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
